// File: rtl/tinyriscv_pkg.sv
// Shared constants for the trap controller: bus widths, FSM states,
// CSR addresses, trap cause codes and system instruction encodings.
package tinyriscv_pkg;

    localparam int InstAddrBus = 32;   // instruction address width
    localparam int RegBus      = 32;   // CSR data width
    localparam int MemAddrBus  = 32;   // CSR address width

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_MEPC         = 3'd1,
        S_MSTATUS      = 3'd2,
        S_MCAUSE       = 3'd3,
        S_MRET_MSTATUS = 3'd4,
        S_ASSERT       = 3'd5
    } trap_state_e;

    localparam logic [MemAddrBus-1:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [MemAddrBus-1:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [MemAddrBus-1:0] CSR_MCAUSE  = 32'h0000_0342;

    localparam logic [RegBus-1:0] CAUSE_ECALL     = 32'h0000_000B;
    localparam logic [RegBus-1:0] CAUSE_EBREAK    = 32'h0000_0003;
    localparam logic [RegBus-1:0] CAUSE_TIMER_IRQ = 32'h8000_0007;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Trap entry: save the interrupt enable into MPIE and disable interrupts.
    function automatic logic [RegBus-1:0] mstatus_on_trap(input logic [RegBus-1:0] ms);
        logic [RegBus-1:0] r;
        r               = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    // Trap return: restore the interrupt enable from MPIE and set MPIE.
    function automatic logic [RegBus-1:0] mstatus_on_mret(input logic [RegBus-1:0] ms);
        logic [RegBus-1:0] r;
        r               = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous timer interrupt request.
// Only built when TRAP_CTRL_IRQ_SYNC_EN is defined.
`ifdef TRAP_CTRL_IRQ_SYNC_EN
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule
`endif

// File: rtl/trap_ctrl.sv
// trap_ctrl: takes ECALL/EBREAK/timer-interrupt traps and MRET returns,
// sequences the mepc/mstatus/mcause CSR writes and issues a one-cycle
// redirect to the control block. Define TRAP_CTRL_IRQ_SYNC_EN to pass
// irq_i through a two-flop synchronizer before use.
module trap_ctrl
    import tinyriscv_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   irq_i,
    input  logic [31:0]            inst_i,
    input  logic [InstAddrBus-1:0] inst_addr_i,
    input  logic                   jump_flag_i,
    input  logic [InstAddrBus-1:0] jump_addr_i,
    input  logic                   div_busy_i,
    input  logic [RegBus-1:0]      csr_mtvec_i,
    input  logic [RegBus-1:0]      csr_mepc_i,
    input  logic [RegBus-1:0]      csr_mstatus_i,
    output logic                   hold_flag_o,
    output logic                   csr_we_o,
    output logic [MemAddrBus-1:0]  csr_waddr_o,
    output logic [RegBus-1:0]      csr_wdata_o,
    output logic                   int_assert_o,
    output logic [InstAddrBus-1:0] int_addr_o
);

    logic w_irq;

`ifdef TRAP_CTRL_IRQ_SYNC_EN
    sync_2ff u_irq_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (irq_i),
        .q_o    (w_irq)
    );
`else
    assign w_irq = irq_i;
`endif

    trap_state_e            r_state;
    trap_state_e            w_state_nxt;
    logic [RegBus-1:0]      r_cause;
    logic [InstAddrBus-1:0] r_mepc;
    logic                   r_mret;

    logic                   w_evt_trap;
    logic                   w_evt_mret;
    logic [RegBus-1:0]      w_evt_cause;
    logic [InstAddrBus-1:0] w_evt_mepc;

    logic                   w_hold;
    logic                   w_we;
    logic [MemAddrBus-1:0]  w_waddr;
    logic [RegBus-1:0]      w_wdata;
    logic                   w_int_assert;
    logic [InstAddrBus-1:0] w_int_addr;

    // Prioritised event decode; suppressed while reset is held so every output stays low.
    always_comb begin
        w_evt_trap  = 1'b0;
        w_evt_mret  = 1'b0;
        w_evt_cause = 32'h0000_0000;
        w_evt_mepc  = inst_addr_i;
        if (!rst_ni) begin
            w_evt_trap = 1'b0;
        end else if (inst_i == INST_ECALL) begin
            w_evt_trap  = 1'b1;
            w_evt_cause = CAUSE_ECALL;
        end else if (inst_i == INST_EBREAK) begin
            w_evt_trap  = 1'b1;
            w_evt_cause = CAUSE_EBREAK;
        end else if (inst_i == INST_MRET) begin
            w_evt_mret = 1'b1;
        end else if (w_irq && csr_mstatus_i[MSTATUS_MIE] && !div_busy_i) begin
            w_evt_trap  = 1'b1;
            w_evt_cause = CAUSE_TIMER_IRQ;
            // A redirecting instruction has already retired; resume at its target.
            w_evt_mepc  = jump_flag_i ? jump_addr_i : inst_addr_i;
        end else begin
            w_evt_trap = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture cause, return address and path type when an event is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cause <= 32'h0000_0000;
            r_mepc  <= 32'h0000_0000;
            r_mret  <= 1'b0;
        end else if ((r_state == S_IDLE) && (w_evt_trap || w_evt_mret)) begin
            r_cause <= w_evt_cause;
            r_mepc  <= w_evt_mepc;
            r_mret  <= w_evt_mret;
        end
    end

    // Next-state and output decode; CSR bus is zero unless a write is strobed.
    always_comb begin
        w_state_nxt  = r_state;
        w_hold       = 1'b0;
        w_we         = 1'b0;
        w_waddr      = 32'h0000_0000;
        w_wdata      = 32'h0000_0000;
        w_int_assert = 1'b0;
        w_int_addr   = 32'h0000_0000;
        case (r_state)
            S_IDLE: begin
                if (w_evt_trap) begin
                    w_hold      = 1'b1;
                    w_state_nxt = S_MEPC;
                end else if (w_evt_mret) begin
                    w_hold      = 1'b1;
                    w_state_nxt = S_MRET_MSTATUS;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MEPC: begin
                w_hold      = 1'b1;
                w_we        = 1'b1;
                w_waddr     = CSR_MEPC;
                w_wdata     = r_mepc;
                w_state_nxt = S_MSTATUS;
            end
            S_MSTATUS: begin
                w_hold      = 1'b1;
                w_we        = 1'b1;
                w_waddr     = CSR_MSTATUS;
                w_wdata     = mstatus_on_trap(csr_mstatus_i);
                w_state_nxt = S_MCAUSE;
            end
            S_MCAUSE: begin
                w_hold      = 1'b1;
                w_we        = 1'b1;
                w_waddr     = CSR_MCAUSE;
                w_wdata     = r_cause;
                w_state_nxt = S_ASSERT;
            end
            S_MRET_MSTATUS: begin
                w_hold      = 1'b1;
                w_we        = 1'b1;
                w_waddr     = CSR_MSTATUS;
                w_wdata     = mstatus_on_mret(csr_mstatus_i);
                w_state_nxt = S_ASSERT;
            end
            S_ASSERT: begin
                w_hold       = 1'b1;
                w_int_assert = 1'b1;
                w_int_addr   = r_mret ? csr_mepc_i : (csr_mtvec_i & 32'hFFFF_FFFC);
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign hold_flag_o  = w_hold;
    assign csr_we_o     = w_we;
    assign csr_waddr_o  = w_waddr;
    assign csr_wdata_o  = w_wdata;
    assign int_assert_o = w_int_assert;
    assign int_addr_o   = w_int_addr;

endmodule
